// File: rtl/dds_sweep_ctrl_if.sv
// Control bundle between the command/register layer and the DDS sweep sequencer.
// Carries the sweep configuration in and the DDS fre/pha words and status out.
interface dds_sweep_ctrl_if #(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned DWELL_WIDTH = 16
);
  logic [PHASE_WIDTH-1:0] cfg_start_freq;
  logic [PHASE_WIDTH-1:0] cfg_stop_freq;
  logic [PHASE_WIDTH-1:0] cfg_step;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [1:0]             cfg_mode;
  logic [PHASE_WIDTH-1:0] cfg_phase;
  logic                   start;
  logic                   abort;

  logic [PHASE_WIDTH-1:0] fre_word;
  logic [PHASE_WIDTH-1:0] pha_word;
  logic                   busy;
  logic                   done;
  logic                   step_tick;
  logic [15:0]            sweep_cnt;

  modport master (
    output cfg_start_freq, cfg_stop_freq, cfg_step, cfg_dwell, cfg_mode, cfg_phase,
    output start, abort,
    input  fre_word, pha_word, busy, done, step_tick, sweep_cnt
  );

  modport slave (
    input  cfg_start_freq, cfg_stop_freq, cfg_step, cfg_dwell, cfg_mode, cfg_phase,
    input  start, abort,
    output fre_word, pha_word, busy, done, step_tick, sweep_cnt
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep sequencer feeding the DDS fre_word/pha_word inputs.
// Supports single, repeat (sawtooth) and bounce (triangle) sweeps with a per-step dwell.
module dds_sweep_ctrl #(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  dds_sweep_ctrl_if.slave    bus
);

  localparam int unsigned PW = PHASE_WIDTH;
  localparam int unsigned DW = DWELL_WIDTH;
  localparam int unsigned EW = PHASE_WIDTH + 1;

  localparam logic [1:0] MODE_REPEAT = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PW-1:0] start_f;
    logic [PW-1:0] stop_f;
    logic [PW-1:0] step;
    logic [DW-1:0] dwell_m1;
    logic [1:0]    mode;
  } cfg_t;

  state_t        r_state;
  cfg_t          r_cfg;
  logic [PW-1:0] r_fre;
  logic [PW-1:0] r_pha;
  logic          r_busy;
  logic          r_done;
  logic          r_step_tick;
  logic [15:0]   r_sweep_cnt;
  logic          r_dir_dn;
  logic [DW-1:0] r_dwell_cnt;

  logic [EW-1:0] w_up;
  logic [EW-1:0] w_dn;
  logic          w_degen;
  logic          w_up_ok;
  logic          w_dn_ok;
  logic          w_fwd_ok;
  logic [PW-1:0] w_fwd_val;
  logic          w_rev_ok;
  logic [PW-1:0] w_rev_val;
  logic [DW-1:0] w_dwell_m1;

  // Candidate next words in both directions, range-checked with one extra bit for carry/borrow.
  always_comb begin
    w_up      = {1'b0, r_fre} + {1'b0, r_cfg.step};
    w_dn      = {1'b0, r_fre} - {1'b0, r_cfg.step};
    w_degen   = (r_cfg.step == '0) || (r_cfg.start_f >= r_cfg.stop_f);
    w_up_ok   = !w_degen && !w_up[PW] && (w_up[PW-1:0] <= r_cfg.stop_f);
    w_dn_ok   = !w_degen && !w_dn[PW] && (w_dn[PW-1:0] >= r_cfg.start_f);
    w_fwd_ok  = r_dir_dn ? w_dn_ok : w_up_ok;
    w_fwd_val = r_dir_dn ? w_dn[PW-1:0] : w_up[PW-1:0];
    w_rev_ok  = r_dir_dn ? w_up_ok : w_dn_ok;
    w_rev_val = r_dir_dn ? w_up[PW-1:0] : w_dn[PW-1:0];
  end

  // A dwell of zero behaves like one; the counter holds remaining cycles after the current one.
  always_comb begin
    w_dwell_m1 = '0;
    if (bus.cfg_dwell != '0) begin
      w_dwell_m1 = bus.cfg_dwell - DW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cfg       <= '0;
      r_fre       <= '0;
      r_pha       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_step_tick <= 1'b0;
      r_sweep_cnt <= '0;
      r_dir_dn    <= 1'b0;
      r_dwell_cnt <= '0;
    end else begin
      r_step_tick <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_cfg.start_f  <= bus.cfg_start_freq;
            r_cfg.stop_f   <= bus.cfg_stop_freq;
            r_cfg.step     <= bus.cfg_step;
            r_cfg.dwell_m1 <= w_dwell_m1;
            r_cfg.mode     <= bus.cfg_mode;
            r_fre          <= bus.cfg_start_freq;
            r_pha          <= bus.cfg_phase;
            r_busy         <= 1'b1;
            r_step_tick    <= 1'b1;
            r_sweep_cnt    <= '0;
            r_dir_dn       <= 1'b0;
            r_dwell_cnt    <= w_dwell_m1;
            r_state        <= S_DWELL;
          end
        end

        S_DWELL: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_dwell_cnt != '0) begin
            r_dwell_cnt <= r_dwell_cnt - DW'(1);
          end else begin
            // Last dwell cycle: the step is evaluated here so no bubble appears.
            r_dwell_cnt <= r_cfg.dwell_m1;
            if (w_fwd_ok) begin
              r_fre       <= w_fwd_val;
              r_step_tick <= 1'b1;
            end else begin
              case (r_cfg.mode)
                MODE_REPEAT: begin
                  r_fre       <= r_cfg.start_f;
                  r_step_tick <= 1'b1;
                  r_sweep_cnt <= r_sweep_cnt + 16'(1);
                end
                MODE_BOUNCE: begin
                  r_dir_dn <= !r_dir_dn;
                  if (r_dir_dn) begin
                    r_sweep_cnt <= r_sweep_cnt + 16'(1);
                  end
                  // Range narrower than step: hold the current word for another dwell.
                  if (w_rev_ok) begin
                    r_fre       <= w_rev_val;
                    r_step_tick <= 1'b1;
                  end
                end
                default: begin
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_sweep_cnt <= r_sweep_cnt + 16'(1);
                  r_state     <= S_DONE;
                end
              endcase
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fre_word  = r_fre;
  assign bus.pha_word  = r_pha;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.step_tick = r_step_tick;
  assign bus.sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed sweep scenarios plus randomized traffic,
// all checked every cycle against a cycle-level behavioural model of the sweep rules.
module tb_dds_sweep_ctrl;
  localparam int unsigned PW = 32;
  localparam int unsigned DW = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dds_sweep_ctrl_if #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) bus();

  dds_sweep_ctrl #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: frequencies held as wide integers, range checked arithmetically.
  longint      m_start, m_stop, m_step, m_cur;
  int          m_dwell, m_left, m_mode;
  bit          m_dn, m_busy, m_done, m_tick, m_in_done;
  logic [31:0] m_pha;
  logic [15:0] m_cnt;

  logic [31:0] fr [0:31];
  logic [15:0] cn [0:31];
  bit          tk [0:31];
  bit          bz [0:31];
  int          done_at;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit try_dir(input bit dn, output longint v);
    v = m_cur;
    if (m_step == 0 || m_start >= m_stop) return 1'b0;
    if (!dn) begin
      v = m_cur + m_step;
      return v <= m_stop;
    end
    v = m_cur - m_step;
    return v >= m_start;
  endfunction

  task automatic model_edge();
    longint v;
    if (reset) begin
      m_cur = 0; m_pha = '0; m_busy = 0; m_done = 0; m_tick = 0; m_cnt = '0;
      m_dn = 0; m_in_done = 0; m_left = 0;
      return;
    end
    m_tick = 0;
    m_done = 0;
    if (m_in_done) begin
      m_in_done = 0;
    end else if (!m_busy) begin
      if (bus.start && !bus.abort) begin
        m_start = longint'(bus.cfg_start_freq);
        m_stop  = longint'(bus.cfg_stop_freq);
        m_step  = longint'(bus.cfg_step);
        m_dwell = (bus.cfg_dwell == '0) ? 1 : int'(bus.cfg_dwell);
        m_mode  = int'(bus.cfg_mode);
        m_left  = m_dwell;
        m_cur   = m_start;
        m_pha   = bus.cfg_phase;
        m_busy  = 1; m_tick = 1; m_cnt = '0; m_dn = 0;
      end
    end else if (bus.abort) begin
      m_busy = 0;
    end else if (m_left > 1) begin
      m_left--;
    end else begin
      m_left = m_dwell;
      if (try_dir(m_dn, v)) begin
        m_cur = v; m_tick = 1;
      end else if (m_mode == 1) begin
        m_cur = m_start; m_tick = 1; m_cnt++;
      end else if (m_mode == 2) begin
        if (m_dn) m_cnt++;
        m_dn = !m_dn;
        if (try_dir(m_dn, v)) begin
          m_cur = v; m_tick = 1;
        end
      end else begin
        m_busy = 0; m_done = 1; m_in_done = 1; m_cnt++;
      end
    end
  endtask

  // One clock: model advances on the edge, DUT is compared on the falling edge.
  task automatic cyc();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    chk("fre_word",  64'(bus.fre_word),  64'(m_cur[31:0]));
    chk("pha_word",  64'(bus.pha_word),  64'(m_pha));
    chk("busy",      64'(bus.busy),      64'(m_busy));
    chk("done",      64'(bus.done),      64'(m_done));
    chk("step_tick", 64'(bus.step_tick), 64'(m_tick));
    chk("sweep_cnt", 64'(bus.sweep_cnt), 64'(m_cnt));
  endtask

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                         input logic [15:0] d, input logic [1:0] md, input logic [31:0] ph);
    bus.cfg_start_freq = s;
    bus.cfg_stop_freq  = p;
    bus.cfg_step       = st;
    bus.cfg_dwell      = d;
    bus.cfg_mode       = md;
    bus.cfg_phase      = ph;
  endtask

  task automatic snap(input int c);
    fr[c] = bus.fre_word;
    cn[c] = bus.sweep_cnt;
    tk[c] = bus.step_tick;
    bz[c] = bus.busy;
    if (bus.done && done_at == 0) done_at = c;
  endtask

  // Start pulse on edge 0; leaves the bench in cycle 1 with values captured for cycles 1..n.
  task automatic start_capture(input int n);
    done_at = 0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    snap(1);
    for (int c = 2; c <= n; c++) begin
      cyc();
      snap(c);
    end
  endtask

  task automatic stop_sweep();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    cyc();
  endtask

  logic [31:0] bounce_exp [0:9];
  logic [31:0] r_s, r_p, r_st;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(32'd0, 32'd0, 32'd0, 16'd0, 2'd0, 32'd0);
    cyc();
    cyc();
    chk("rst_fre", 64'(bus.fre_word), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;
    cyc();

    // Single sweep 100..400 step 100 dwell 3
    set_cfg(32'd100, 32'd400, 32'd100, 16'd3, 2'd0, 32'h0000_1234);
    start_capture(15);
    chk("single_c1", 64'(fr[1]), 64'd100);
    chk("single_c3", 64'(fr[3]), 64'd100);
    chk("single_c4", 64'(fr[4]), 64'd200);
    chk("single_c7", 64'(fr[7]), 64'd300);
    chk("single_c12", 64'(fr[12]), 64'd400);
    chk("single_done_at", 64'(done_at), 64'd13);
    chk("single_hold", 64'(fr[15]), 64'd400);
    chk("single_tick10", 64'(tk[10]), 64'd1);
    chk("single_tick11", 64'(tk[11]), 64'd0);
    chk("single_cnt", 64'(cn[15]), 64'd1);

    // Overshoot: stop between steps
    set_cfg(32'd100, 32'd350, 32'd100, 16'd3, 2'd0, 32'h0);
    start_capture(12);
    chk("over_done_at", 64'(done_at), 64'd10);
    chk("over_last", 64'(fr[11]), 64'd300);

    // Carry out of the top of the word must end the sweep, not wrap
    set_cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd1, 2'd0, 32'h0);
    start_capture(5);
    chk("carry_c1", 64'(fr[1]), 64'hFFFF_FF00);
    chk("carry_c2", 64'(fr[2]), 64'hFFFF_FF80);
    chk("carry_done_at", 64'(done_at), 64'd3);
    chk("carry_hold", 64'(fr[4]), 64'hFFFF_FF80);

    // Repeat sawtooth dwell 2
    set_cfg(32'd100, 32'd300, 32'd100, 16'd2, 2'd1, 32'h0);
    start_capture(10);
    chk("rep_c5", 64'(fr[5]), 64'd300);
    chk("rep_c7", 64'(fr[7]), 64'd100);
    chk("rep_cnt6", 64'(cn[6]), 64'd0);
    chk("rep_cnt7", 64'(cn[7]), 64'd1);
    chk("rep_busy", 64'(bz[10]), 64'd1);
    stop_sweep();

    // Bounce triangle dwell 1
    bounce_exp = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd300,
                   32'd200, 32'd100, 32'd200, 32'd300, 32'd400};
    set_cfg(32'd100, 32'd400, 32'd100, 16'd1, 2'd2, 32'h0);
    start_capture(10);
    for (int c = 1; c <= 10; c++) chk("bounce_seq", 64'(fr[c]), 64'(bounce_exp[c-1]));
    chk("bounce_cnt7", 64'(cn[7]), 64'd0);
    chk("bounce_cnt8", 64'(cn[8]), 64'd1);
    stop_sweep();

    // Bounce with range narrower than step holds the start word
    set_cfg(32'd100, 32'd150, 32'd100, 16'd1, 2'd2, 32'h0);
    start_capture(5);
    chk("narrow_c4", 64'(fr[4]), 64'd100);
    chk("narrow_tick2", 64'(tk[2]), 64'd0);
    chk("narrow_tick3", 64'(tk[3]), 64'd0);
    chk("narrow_cnt3", 64'(cn[3]), 64'd1);
    stop_sweep();

    // Abort at edge 5, ignored restart at edge 2
    set_cfg(32'd100, 32'd400, 32'd100, 16'd3, 2'd0, 32'h0000_5555);
    done_at = 0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    snap(1);
    set_cfg(32'd700, 32'd900, 32'd10, 16'd1, 2'd1, 32'h0000_DEAD);
    for (int c = 2; c <= 14; c++) begin
      bus.start = (c == 3);
      bus.abort = (c == 6);
      cyc();
      snap(c);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_c4", 64'(fr[4]), 64'd200);
    chk("abort_busy5", 64'(bz[5]), 64'd1);
    chk("abort_busy6", 64'(bz[6]), 64'd0);
    chk("abort_hold", 64'(fr[14]), 64'd200);
    chk("abort_nodone", 64'(done_at), 64'd0);
    chk("abort_pha", 64'(bus.pha_word), 64'h5555);

    // Dwell 0 acts as dwell 1
    set_cfg(32'd100, 32'd300, 32'd100, 16'd0, 2'd0, 32'h0);
    start_capture(5);
    chk("dw0_c2", 64'(fr[2]), 64'd200);
    chk("dw0_c3", 64'(fr[3]), 64'd300);
    chk("dw0_done_at", 64'(done_at), 64'd4);

    // Reset mid-sweep, then a fresh sweep
    set_cfg(32'd100, 32'd300, 32'd100, 16'd1, 2'd1, 32'h1111_1111);
    start_capture(7);
    chk("mid_cnt_pre", 64'(cn[7]), 64'd2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_rst_fre", 64'(bus.fre_word), 64'd0);
    chk("mid_rst_pha", 64'(bus.pha_word), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_cnt", 64'(bus.sweep_cnt), 64'd0);
    set_cfg(32'd100, 32'd400, 32'd100, 16'd3, 2'd0, 32'h4000_0000);
    start_capture(14);
    chk("fresh_pha", 64'(bus.pha_word), 64'h4000_0000);
    chk("fresh_c4", 64'(fr[4]), 64'd200);
    chk("fresh_done_at", 64'(done_at), 64'd13);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r_s  = 32'hFFFF_FF00 | 32'($urandom_range(0, 127));
        r_p  = 32'hFFFF_FFFF - 32'($urandom_range(0, 64));
        r_st = 32'($urandom_range(1, 256));
      end else begin
        r_s  = 32'($urandom_range(0, 1000));
        r_p  = 32'($urandom_range(0, 1500));
        r_st = 32'($urandom_range(0, 400));
      end
      set_cfg(r_s, r_p, r_st, 16'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), $urandom);
      bus.start = ($urandom_range(0, 14) == 0);
      bus.abort = ($urandom_range(0, 79) == 0);
      reset     = ($urandom_range(0, 399) == 0);
      cyc();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    reset     = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer that drives the fre_word/pha_word control inputs of the DDS core to perform linear frequency sweeps.
- Sweep is defined by start, stop, step and dwell time.
- Sweep modes: single, repeat (sawtooth) and bounce (triangle).
- Sits between the command/register layer and the DDS instance; the DDS consumes its outputs directly.

Parameters:
PHASE_WIDTH, 32, width of frequency/phase words (matches DDS)
DWELL_WIDTH, 16, width of dwell counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
cfg_start_freq  in  PHASE_WIDTH  first frequency word of sweep
cfg_stop_freq  in  PHASE_WIDTH  upper bound frequency word
cfg_step  in  PHASE_WIDTH  frequency increment per step
cfg_dwell  in  DWELL_WIDTH  clocks each frequency is held (0 treated as 1)
cfg_mode  in  2  0=single, 1=repeat, 2=bounce, 3=reserved (acts as single)
cfg_phase  in  PHASE_WIDTH  phase offset word
start  in  1  start pulse
abort  in  1  stop sweep immediately
fre_word  out  PHASE_WIDTH  to DDS fre_word
pha_word  out  PHASE_WIDTH  to DDS pha_word
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at normal completion of single sweep
step_tick  out  1  one-cycle pulse in each cycle fre_word takes a new value
sweep_cnt  out  16  completed sweeps since start, wraps at 0xFFFF

Behaviour:
Interface and reset
- Clock is clock; reset is reset, synchronous, active-high.
- Reset values: fre_word=0, pha_word=0, busy=0, done=0, step_tick=0, sweep_cnt=0, state=IDLE, direction=up.
- Reset mid-sweep returns to these values on the next edge.

States: IDLE, DWELL, STEP, DONE.

IDLE
- On start=1 (edge N), latch all cfg_* inputs.
- At N+1: fre_word=start_freq, pha_word=cfg_phase, busy=1, step_tick=1, sweep_cnt=0, direction=up; go to DWELL.
- start while busy is ignored.

DWELL
- Hold fre_word for D = max(cfg_dwell,1) cycles, including the load cycle.
- After the D-th cycle, compute the next value (STEP is combinational with the last dwell cycle); the new fre_word appears on the cycle after the D-th.
- No bubble cycles: each value occupies exactly D cycles.

Step arithmetic
- Computed in PHASE_WIDTH+1 bits.
- Up: nxt = cur + step. Out of range if carry set or nxt > stop.
- Down: nxt = cur − step. Out of range if borrow or nxt < start.
- In range: fre_word = nxt, step_tick = 1.

Out-of-range handling by mode
- single (and mode 3): go to DONE. fre_word holds the last value; busy=0 and done=1 in the cycle after the final dwell; sweep_cnt += 1. DONE→IDLE next cycle.
- repeat: fre_word = start, step_tick=1, sweep_cnt += 1.
- bounce: flip direction and apply step in the new direction.
  - If that is also out of range (range < step), hold cur for another dwell, step_tick=0.
  - sweep_cnt += 1 on each down→up flip.

Degenerate configurations
- cfg_step=0 or start ≥ stop: hold start for one dwell, then treat as out of range per mode.
  - repeat holds start indefinitely; step_tick pulses every D cycles.

Abort
- abort=1 in any busy state: next cycle busy=0, state=IDLE, no done pulse, fre_word/pha_word hold current values.
- abort has priority over a same-cycle step.
- abort in IDLE has no effect; abort together with start in IDLE means abort wins (no start).

General
- pha_word changes only on start.
- Outputs are registered; the DDS sees changes one clock after the controller's edge.

Test Plan:
- Single: start=100, stop=400, step=100, dwell=3, start at cycle 0 → fre_word 100 @1-3, 200 @4-6, 300 @7-9, 400 @10-12; done=1 and busy=0 @13; fre_word stays 400; step_tick @1,4,7,10; sweep_cnt=1.
- Overshoot/overflow: stop=350 → last freq 300, done @10. Separately start=0xFFFFFF00, stop=0xFFFFFFFF, step=0x80, dwell=1 → 0xFFFFFF00, 0xFFFFFF80, then done (carry detected, no wrap to 0x00000000).
- Repeat: start=100, stop=300, step=100, dwell=2 → 100,100,200,200,300,300,100,… with sweep_cnt incrementing on each return to 100.
- Bounce: start=100, stop=400, step=100, dwell=1 → 100,200,300,400,300,200,100,200,…; sweep_cnt increments when 200 follows 100. Range-smaller-than-step case (stop=150) holds 100 with step_tick=0.
- Abort and start-while-busy: abort at cycle 5 of the first test → busy=0 @6, fre_word=200 held, done never asserted. A second start at cycle 2 is ignored. dwell=0 behaves as dwell=1.
- Reset mid-sweep at cycle 7 → next cycle fre_word=0, pha_word=0, busy=0, sweep_cnt=0; a fresh start then sweeps normally with cfg_phase=0x40000000 appearing on pha_word.
